dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the processor core load/store path and an external loader port, used for image preload and result readback.
- Grants one requester per cycle.
- Drives the memory wr_en/rd_en/addr/dat_in controls.
- Registers read data back to the winning requester.
- Stalls the core (freezes the PC) whenever its access is not granted.

Parameters:
- AW, 8, memory address width.
- DW, 8, data width.
- MAX_WAIT, 4, consecutive denied loader-request cycles before the loader is forced to priority (1..15).
- BURST_MAX, 8, maximum consecutive locked loader grants before a forced release.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- core_req  in  1  core memory access request.
- core_we  in  1  1=store, 0=load.
- core_addr  in  AW  core address.
- core_wdata  in  DW  core store data.
- core_gnt  out  1  core access accepted this cycle (combinational).
- core_stall  out  1  core_req & ~core_gnt; holds the PC.
- core_rdata  out  DW  registered load data.
- core_rvalid  out  1  core_rdata valid (one cycle).
- ld_req  in  1  loader request.
- ld_we  in  1  loader write enable.
- ld_addr  in  AW  loader address.
- ld_wdata  in  DW  loader write data.
- ld_lock  in  1  loader requests grant retention for the next beat.
- ld_gnt  out  1  loader access accepted this cycle (combinational).
- ld_rdata  out  DW  registered loader read data.
- ld_rvalid  out  1  ld_rdata valid (one cycle).
- mem_wr_en  out  1  memory write strobe.
- mem_rd_en  out  1  memory read enable.
- mem_addr  out  AW  memory address.
- mem_dat_in  out  DW  memory write data.
- mem_dat_out  in  DW  memory read data, combinational from mem_addr.
- stall_cnt  out  16  core stall cycle count (see Optional Feature).

Behaviour:
- **Reset** (reset low, asynchronous):
  - state=IDLE, wait_cnt=0, beat_cnt=0.
  - All rvalid=0, rdata=0, stall_cnt=0.
  - Memory strobes 0.
  - Grants are 0 while reset is low.
  - Reset mid-burst aborts the burst; no write is issued during the reset cycle.
- **States:** IDLE, CORE, LOAD. The state reflects the previous cycle's owner; grant decisions are combinational per cycle.
- **Arbitration, per cycle:**
  - 1. If state=LOAD, ld_lock was high last cycle, ld_req is high and beat_cnt<BURST_MAX: grant loader.
  - 2. Else if ld_req and wait_cnt>=MAX_WAIT: grant loader.
  - 3. Else if core_req: grant core.
  - 4. Else if ld_req: grant loader.
  - 5. Else no grant.
  - At most one grant is high.
- **Next state:** CORE if core granted, LOAD if loader granted, else IDLE.
- **wait_cnt:**
  - Increments (saturating at 15) when ld_req is high and ld_gnt is low.
  - Clears on ld_gnt or when ld_req is low.
- **beat_cnt:**
  - Increments on each loader grant while in LOAD.
  - Resets to 1 on entry to LOAD and to 0 outside LOAD.
  - When beat_cnt reaches BURST_MAX, the lock is ignored for one arbitration, so a pending core request wins.
- **Memory drive:**
  - Granted requester's addr/wdata pass to mem_addr/mem_dat_in.
  - mem_wr_en = gnt & we; mem_rd_en = gnt & ~we.
  - With no grant: mem_addr=0, strobes 0.
- **Read return, 1-cycle latency:** on a granted read, mem_dat_out is registered into that requester's rdata, and its rvalid is high the next cycle only. A write produces no rvalid.
- **Stall:** core_stall is combinational; the core must hold its request fields stable while stalled. The loader must do the same while ld_gnt is low.
- A request withdrawn before grant is dropped silently; no state is left behind except wait_cnt clearing.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- When defined:
  - 16-bit stall_cnt increments every cycle core_stall=1, saturating at 16'hFFFF.
  - Clears on reset.
- When undefined: stall_cnt is tied to 0 and no counter logic is synthesized.

Test Plan:
- Core only: core load addr 8'h10, memory holds 8'hA5 -> core_gnt same cycle, core_rvalid=1 with core_rdata=8'hA5 next cycle, core_stall=0 throughout.
- Simultaneous single requests: core store and loader read in the same cycle -> core wins, ld_gnt=0, loader granted the following cycle if the core drops its request.
- Starvation: core_req held high continuously with ld_req high -> ld_gnt on the 5th cycle (wait_cnt=4), core_stall=1 that cycle, core regranted the next cycle.
- Locked burst: loader writes 10 beats with ld_lock=1 and core_req high -> 8 loader grants, then 1 core grant, then the loader resumes; memory contents match all 10 writes.
- Reset mid-burst: reset low during loader beat 3 -> grants, strobes and rvalid drop immediately; after release, state=IDLE and beat_cnt=0.
- With DMEM_ARB_STATS_EN: 6 stalled core cycles -> stall_cnt=6. Without the macro: stall_cnt=0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the core load/store path and the external loader port.
// Optional stall statistics counter enabled by defining DMEM_ARB_STATS_EN.
module dmem_arbiter #(
  parameter int unsigned AW        = 8,
  parameter int unsigned DW        = 8,
  parameter int unsigned MAX_WAIT  = 4,
  parameter int unsigned BURST_MAX = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic          core_gnt,
  output logic          core_stall,
  output logic [DW-1:0] core_rdata,
  output logic          core_rvalid,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  input  logic          ld_lock,
  output logic          ld_gnt,
  output logic [DW-1:0] ld_rdata,
  output logic          ld_rvalid,
  output logic          mem_wr_en,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_dat_in,
  input  logic [DW-1:0] mem_dat_out,
  output logic [15:0]   stall_cnt
);

  localparam int unsigned BW = $clog2(BURST_MAX + 1);

  typedef enum logic [1:0] {IDLE, CORE, LOAD} state_t;

  state_t        state_q, state_d;
  logic [3:0]    wait_cnt;
  logic [BW-1:0] beat_cnt;
  logic          lock_q;

  always_comb begin
    core_gnt = 1'b0;
    ld_gnt   = 1'b0;
    if (!reset) begin
      core_gnt = 1'b0;
      ld_gnt   = 1'b0;
    end else if (state_q == LOAD && lock_q && ld_req && beat_cnt < BW'(BURST_MAX)) begin
      ld_gnt = 1'b1;
    end else if (ld_req && wait_cnt >= 4'(MAX_WAIT)) begin
      ld_gnt = 1'b1;
    end else if (core_req) begin
      core_gnt = 1'b1;
    end else if (ld_req) begin
      ld_gnt = 1'b1;
    end
  end

  always_comb begin
    state_d = IDLE;
    if (core_gnt)    state_d = CORE;
    else if (ld_gnt) state_d = LOAD;
  end

  assign core_stall = core_req & ~core_gnt;

  always_comb begin
    mem_wr_en  = 1'b0;
    mem_rd_en  = 1'b0;
    mem_addr   = '0;
    mem_dat_in = '0;
    if (core_gnt) begin
      mem_wr_en  = core_we;
      mem_rd_en  = ~core_we;
      mem_addr   = core_addr;
      mem_dat_in = core_wdata;
    end else if (ld_gnt) begin
      mem_wr_en  = ld_we;
      mem_rd_en  = ~ld_we;
      mem_addr   = ld_addr;
      mem_dat_in = ld_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lock_q  <= ld_lock;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (ld_req && !ld_gnt) begin
      if (wait_cnt != 4'hF) wait_cnt <= wait_cnt + 4'd1;
    end else begin
      wait_cnt <= '0;
    end
  end

  // A loader grant at beat_cnt==BURST_MAX (lock ignored, nobody else waiting)
  // opens a fresh burst rather than overrunning the counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_cnt <= '0;
    end else if (ld_gnt) begin
      if (state_q == LOAD && beat_cnt < BW'(BURST_MAX)) beat_cnt <= beat_cnt + BW'(1);
      else                                               beat_cnt <= BW'(1);
    end else begin
      beat_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      core_rvalid <= 1'b0;
      core_rdata  <= '0;
      ld_rvalid   <= 1'b0;
      ld_rdata    <= '0;
    end else begin
      core_rvalid <= core_gnt & ~core_we;
      ld_rvalid   <= ld_gnt & ~ld_we;
      if (core_gnt && !core_we) core_rdata <= mem_dat_out;
      if (ld_gnt && !ld_we)     ld_rdata   <= mem_dat_out;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                stall_cnt <= '0;
    else if (core_stall && stall_cnt != '1)    stall_cnt <= stall_cnt + 16'd1;
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed scoreboard bench for dmem_arbiter: grant/strobe checks at drive time,
// read data checked by a monitor against queued expectations.
module tb_dmem_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       core_req, core_we;
  logic [7:0] core_addr, core_wdata;
  logic       core_gnt, core_stall, core_rvalid;
  logic [7:0] core_rdata;
  logic       ld_req, ld_we, ld_lock;
  logic [7:0] ld_addr, ld_wdata;
  logic       ld_gnt, ld_rvalid;
  logic [7:0] ld_rdata;
  logic       mem_wr_en, mem_rd_en;
  logic [7:0] mem_addr, mem_dat_in, mem_dat_out;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  logic [7:0] core_q[$];
  logic [7:0] ld_q[$];
  logic [7:0] mon_exp;

  logic [7:0] mem [0:255] = '{8'h10: 8'hA5, default: 8'h00};

  always #5 clk = ~clk;

  assign mem_dat_out = mem[mem_addr];
  always @(posedge clk) if (mem_wr_en) mem[mem_addr] <= mem_dat_in;

  dmem_arbiter #(.AW(8), .DW(8), .MAX_WAIT(4), .BURST_MAX(8)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_stall(core_stall), .core_rdata(core_rdata), .core_rvalid(core_rvalid),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_lock(ld_lock),
    .ld_gnt(ld_gnt), .ld_rdata(ld_rdata), .ld_rvalid(ld_rvalid),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_dat_in(mem_dat_in), .mem_dat_out(mem_dat_out), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [7:0] ca, input logic [7:0] cd,
                       input logic lr, input logic lw, input logic [7:0] la, input logic [7:0] lwd,
                       input logic lk);
    @(negedge clk);
    core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
    ld_req = lr; ld_we = lw; ld_addr = la; ld_wdata = lwd; ld_lock = lk;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic expect_gnt(input string nm, input logic ecg, input logic elg);
    #1;
    chk({nm, "_core_gnt"}, 16'(core_gnt), 16'(ecg));
    chk({nm, "_ld_gnt"}, 16'(ld_gnt), 16'(elg));
    chk({nm, "_core_stall"}, 16'(core_stall), 16'(core_req & ~ecg));
    chk({nm, "_wr_en"}, 16'(mem_wr_en), 16'((ecg & core_we) | (elg & ld_we)));
    chk({nm, "_rd_en"}, 16'(mem_rd_en), 16'((ecg & ~core_we) | (elg & ~ld_we)));
  endtask

  always @(negedge clk) begin
    if (core_rvalid) begin
      if (core_q.size() == 0) chk("core_rvalid_unexpected", 16'(core_rvalid), 16'd0);
      else begin
        mon_exp = core_q.pop_front();
        chk("core_rdata", 16'(core_rdata), 16'(mon_exp));
      end
    end
    if (ld_rvalid) begin
      if (ld_q.size() == 0) chk("ld_rvalid_unexpected", 16'(ld_rvalid), 16'd0);
      else begin
        mon_exp = ld_q.pop_front();
        chk("ld_rdata", 16'(ld_rdata), 16'(mon_exp));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    core_req = 1'b1; core_we = 1'b1; core_addr = 8'h10; core_wdata = 8'hEE;
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 8'h11; ld_wdata = 8'hEE; ld_lock = 1'b1;
    @(negedge clk); #1;
    chk("rst_core_gnt", 16'(core_gnt), 16'd0);
    chk("rst_ld_gnt", 16'(ld_gnt), 16'd0);
    chk("rst_wr_en", 16'(mem_wr_en), 16'd0);
    chk("rst_rd_en", 16'(mem_rd_en), 16'd0);
    chk("rst_core_rvalid", 16'(core_rvalid), 16'd0);
    chk("rst_ld_rvalid", 16'(ld_rvalid), 16'd0);
    chk("rst_core_rdata", 16'(core_rdata), 16'd0);
    chk("rst_stall_cnt", stall_cnt, 16'd0);
    chk("rst_no_write", 16'(mem[8'h10]), 16'h00A5);
    @(negedge clk);
    reset = 1'b1;
    core_req = 1'b0; ld_req = 1'b0; ld_lock = 1'b0;

    // core-only load
    drive(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    expect_gnt("core_only", 1'b1, 1'b0);
    chk("core_only_addr", 16'(mem_addr), 16'h0010);
    core_q.push_back(8'hA5);
    idle();
    expect_gnt("core_only_idle", 1'b0, 1'b0);

    // locked 10-beat loader write burst, core store arriving on cycle 2
    for (int c = 0; c <= 10; c++) begin
      automatic int beat = (c <= 8) ? c : c - 1;
      drive((c >= 2 && c <= 8), 1'b1, 8'h20, 8'h5A,
            1'b1, 1'b1, 8'(8'h40 + beat), 8'(8'h80 + beat), 1'b1);
      expect_gnt($sformatf("burst_c%0d", c), (c == 8), (c != 8));
    end
    idle();
    expect_gnt("burst_end", 1'b0, 1'b0);
`ifdef DMEM_ARB_STATS_EN
    chk("stall_cnt", stall_cnt, 16'd6);
`else
    chk("stall_cnt", stall_cnt, 16'd0);
`endif
    for (int i = 0; i < 10; i++)
      chk($sformatf("burst_mem_%0d", i), 16'(mem[8'h40 + i]), 16'(8'h80 + i));
    chk("burst_core_store", 16'(mem[8'h20]), 16'h005A);

    // simultaneous core store and loader read
    drive(1'b1, 1'b1, 8'h30, 8'h33, 1'b1, 1'b0, 8'h41, 8'h00, 1'b0);
    expect_gnt("simul_c0", 1'b1, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h41, 8'h00, 1'b0);
    expect_gnt("simul_c1", 1'b0, 1'b1);
    chk("simul_addr", 16'(mem_addr), 16'h0041);
    ld_q.push_back(8'h81);
    idle();
    expect_gnt("simul_idle", 1'b0, 1'b0);
    chk("simul_core_store", 16'(mem[8'h30]), 16'h0033);

    // starvation: continuous core loads against a pending loader read
    for (int c = 1; c <= 6; c++) begin
      drive(1'b1, 1'b0, 8'h10, 8'h00, (c <= 5), 1'b0, 8'h42, 8'h00, 1'b0);
      expect_gnt($sformatf("starve_c%0d", c), (c != 5), (c == 5));
      if (c == 5) ld_q.push_back(8'h82);
      else        core_q.push_back(8'hA5);
    end
    idle();
    expect_gnt("starve_idle", 1'b0, 1'b0);

    // reset during loader beat 3
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h50, 8'h11, 1'b1);
    expect_gnt("rburst_b1", 1'b0, 1'b1);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h41, 8'h00, 1'b1);
    expect_gnt("rburst_b2", 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("rburst_rvalid_pre", 16'(ld_rvalid), 16'd1);
    chk("rburst_rdata_pre", 16'(ld_rdata), 16'h0081);
    ld_we = 1'b1; ld_addr = 8'h52; ld_wdata = 8'h99;
    #1;
    chk("rburst_b3_gnt_pre", 16'(ld_gnt), 16'd1);
    reset = 1'b0;
    #1;
    chk("rburst_ld_gnt", 16'(ld_gnt), 16'd0);
    chk("rburst_wr_en", 16'(mem_wr_en), 16'd0);
    chk("rburst_ld_rvalid", 16'(ld_rvalid), 16'd0);
    chk("rburst_ld_rdata", 16'(ld_rdata), 16'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    core_req = 1'b0; ld_req = 1'b0; ld_lock = 1'b0;
    #1;
    chk("rburst_beat_cnt", 16'(dut.beat_cnt), 16'd0);
    chk("rburst_stall_cnt", stall_cnt, 16'd0);
    chk("rburst_no_write", 16'(mem[8'h52]), 16'h0000);
    chk("rburst_beat1_kept", 16'(mem[8'h50]), 16'h0011);
    drive(1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'h43, 8'h00, 1'b1);
    expect_gnt("post_reset", 1'b1, 1'b0);
    core_q.push_back(8'hA5);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h43, 8'h00, 1'b0);
    expect_gnt("post_reset_ld", 1'b0, 1'b1);
    ld_q.push_back(8'h83);

    repeat (3) idle();
    chk("core_q_drained", 16'(core_q.size()), 16'd0);
    chk("ld_q_drained", 16'(ld_q.size()), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
